// File: rtl/bus_xfer_ctrl.sv
// Register-transfer sequencer: strobes source rd_bar (or drives an immediate byte),
// then the destination wr_bar, with every output taken straight from a flop.
module bus_xfer_ctrl #(
    parameter int unsigned NREGS = 8,
    parameter int unsigned AW    = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [AW-1:0]    src,
    input  logic [AW-1:0]    dst,
    input  logic             src_imm,
    input  logic [7:0]       imm,
    output logic [NREGS-1:0] rd_bar,
    output logic [NREGS-1:0] wr_bar,
    output logic             bus_oe,
    output logic [7:0]       bus_d,
    output logic             busy,
    output logic             done,
    output logic             err
);

    typedef enum logic [1:0] {StIdle, StDrive, StLatch, StHold} state_e;

    state_e           state_q, state_d;
    logic [AW-1:0]    src_q, src_d;
    logic [AW-1:0]    dst_q, dst_d;
    logic             imm_sel_q, imm_sel_d;
    logic [7:0]       imm_q, imm_d;

    logic [NREGS-1:0] rd_bar_d, wr_bar_d;
    logic             bus_oe_d, busy_d, done_d, err_d;
    logic [7:0]       bus_d_d;
    logic             cmd_legal;

    always_comb begin
        cmd_legal = 1'b1;
        if (32'(dst) >= NREGS) begin
            cmd_legal = 1'b0;
        end
        if (!src_imm && ((32'(src) >= NREGS) || (src == dst))) begin
            cmd_legal = 1'b0;
        end
    end

    // Outputs are decoded from the next state so the registered strobes line up
    // with the state they belong to.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        imm_sel_d = imm_sel_q;
        imm_d     = imm_q;
        done_d    = 1'b0;
        err_d     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (cmd_legal) begin
                        state_d   = StDrive;
                        src_d     = src;
                        dst_d     = dst;
                        imm_sel_d = src_imm;
                        imm_d     = imm;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StDrive: state_d = StLatch;
            StLatch: state_d = StHold;
            StHold: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase

        rd_bar_d = '1;
        wr_bar_d = '1;
        bus_oe_d = 1'b0;
        bus_d_d  = 8'h00;
        busy_d   = (state_d != StIdle);

        if (busy_d) begin
            if (imm_sel_d) begin
                bus_oe_d = 1'b1;
                bus_d_d  = imm_d;
            end else begin
                for (int unsigned i = 0; i < NREGS; i++) begin
                    rd_bar_d[i] = (src_d != AW'(i));
                end
            end
        end
        if (state_d == StLatch) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                wr_bar_d[i] = (dst_d != AW'(i));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            src_q     <= '0;
            dst_q     <= '0;
            imm_sel_q <= 1'b0;
            imm_q     <= 8'h00;
            rd_bar    <= '1;
            wr_bar    <= '1;
            bus_oe    <= 1'b0;
            bus_d     <= 8'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            imm_sel_q <= imm_sel_d;
            imm_q     <= imm_d;
            rd_bar    <= rd_bar_d;
            wr_bar    <= wr_bar_d;
            bus_oe    <= bus_oe_d;
            bus_d     <= bus_d_d;
            busy      <= busy_d;
            done      <= done_d;
            err       <= err_d;
        end
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Directed-vector bench for bus_xfer_ctrl (8 registers, 4-bit index build so that
// out-of-range indices can be presented), plus a random phase with invariant checks.
module tb_bus_xfer_ctrl;

    localparam int unsigned NREGS = 8;
    localparam int unsigned AW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             req;
    logic [AW-1:0]    src;
    logic [AW-1:0]    dst;
    logic             src_imm;
    logic [7:0]       imm;
    logic [NREGS-1:0] rd_bar;
    logic [NREGS-1:0] wr_bar;
    logic             bus_oe;
    logic [7:0]       bus_d;
    logic             busy;
    logic             done;
    logic             err;

    int vectors     = 0;
    int miscompares = 0;
    bit mon_en      = 1'b0;

    bus_xfer_ctrl #(.NREGS(NREGS), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .src     (src),
        .dst     (dst),
        .src_imm (src_imm),
        .imm     (imm),
        .rd_bar  (rd_bar),
        .wr_bar  (wr_bar),
        .bus_oe  (bus_oe),
        .bus_d   (bus_d),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [7:0] e_rd, input logic [7:0] e_wr,
                              input logic e_oe, input logic [7:0] e_d, input logic e_busy,
                              input logic e_done, input logic e_err);
        chk({tag, ".rd_bar"}, 32'(rd_bar), 32'(e_rd));
        chk({tag, ".wr_bar"}, 32'(wr_bar), 32'(e_wr));
        chk({tag, ".bus_oe"}, 32'(bus_oe), 32'(e_oe));
        chk({tag, ".bus_d"},  32'(bus_d),  32'(e_d));
        chk({tag, ".busy"},   32'(busy),   32'(e_busy));
        chk({tag, ".done"},   32'(done),   32'(e_done));
        chk({tag, ".err"},    32'(err),    32'(e_err));
    endtask

    task automatic drive(input logic r, input logic [AW-1:0] s, input logic [AW-1:0] d,
                         input logic si, input logic [7:0] im);
        req     = r;
        src     = s;
        dst     = d;
        src_imm = si;
        imm     = im;
    endtask

    // Bus invariants every cycle, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("inv.rd_onehot0", 32'($onehot0(~rd_bar)), 32'd1);
            chk("inv.wr_onehot0", 32'($onehot0(~wr_bar)), 32'd1);
            chk("inv.oe_rd_overlap", 32'(bus_oe && (rd_bar != '1)), 32'd0);
            chk("inv.bus_d_idle", 32'((!bus_oe) && (bus_d != 8'h00)), 32'd0);
            chk("inv.wr_while_idle", 32'((!busy) && (wr_bar != '1)), 32'd0);
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, '0, 1'b0, 8'h00);
        tick();
        tick();
        expect_out("reset", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();

        // Register move 2 -> 5
        drive(1'b1, 4'd2, 4'd5, 1'b0, 8'h00);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        expect_out("reg.drive", 8'hFB, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("reg.latch", 8'hFB, 8'hDF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("reg.hold", 8'hFB, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("reg.done", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        expect_out("reg.after", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Immediate A5 -> 0; src equal to dst is irrelevant for immediates
        drive(1'b1, 4'd0, 4'd0, 1'b1, 8'hA5);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h3C);
        expect_out("imm.drive", 8'hFF, 8'hFF, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("imm.latch", 8'hFF, 8'hFE, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("imm.hold", 8'hFF, 8'hFF, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("imm.done", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Rejects
        drive(1'b1, 4'd3, 4'd3, 1'b0, 8'h00);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        expect_out("rej.same", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        expect_out("rej.same_clr", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 4'd8, 1'b0, 8'h00);
        tick();
        expect_out("rej.dst8", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd9, 4'd1, 1'b0, 8'h00);
        tick();
        expect_out("rej.src9", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'd0, 4'd12, 1'b1, 8'h77);
        tick();
        expect_out("rej.imm_dst12", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        // Legal command accepted during the err cycle
        drive(1'b1, 4'd1, 4'd2, 1'b0, 8'h00);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        expect_out("rej.accept_next", 8'hFD, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rej.accept_latch", 8'hFD, 8'hFB, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        chk("rej.accept_done", 32'(done), 32'd1);

        // Back-to-back: second req held through the first transfer
        drive(1'b1, 4'd6, 4'd7, 1'b0, 8'h00);
        tick();
        expect_out("b2b.drive1", 8'hBF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 4'd1, 4'd4, 1'b0, 8'h00);
        tick();
        expect_out("b2b.latch1", 8'hBF, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.hold1", 8'hBF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.done1", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        expect_out("b2b.drive2", 8'hFD, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.latch2", 8'hFD, 8'hEF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.hold2", 8'hFD, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("b2b.done2", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Reset during DRIVE
        drive(1'b1, 4'd4, 4'd0, 1'b0, 8'h00);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        expect_out("rst.drive", 8'hEF, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expect_out("rst.cleared", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_out("rst.no_done", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        end
        // Reset wins over a simultaneous req
        rst = 1'b1;
        drive(1'b1, 4'd0, 4'd7, 1'b0, 8'h00);
        tick();
        rst = 1'b0;
        expect_out("rst.priority", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        expect_out("rst.follow_drive", 8'hFE, 8'hFF, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        expect_out("rst.follow_latch", 8'hFE, 8'h7F, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        expect_out("rst.follow_done", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Random legal and illegal traffic; invariants are checked by the monitor
        for (int i = 0; i < 10000; i++) begin
            drive(1'($urandom_range(0, 1)), AW'($urandom_range(0, 9)),
                  AW'($urandom_range(0, 9)), 1'($urandom_range(0, 3) == 0),
                  8'($urandom));
            tick();
        end
        drive(1'b0, 4'd0, 4'd0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        expect_out("rand.settled", 8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
